// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the six-digit clock display scanner.
// Segment codes are active-high, bit order g..a.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG7_0     = 7'h3F;
    localparam logic [6:0] SEG7_1     = 7'h06;
    localparam logic [6:0] SEG7_2     = 7'h5B;
    localparam logic [6:0] SEG7_3     = 7'h4F;
    localparam logic [6:0] SEG7_4     = 7'h66;
    localparam logic [6:0] SEG7_5     = 7'h6D;
    localparam logic [6:0] SEG7_6     = 7'h7D;
    localparam logic [6:0] SEG7_7     = 7'h07;
    localparam logic [6:0] SEG7_8     = 7'h7F;
    localparam logic [6:0] SEG7_9     = 7'h6F;
    localparam logic [6:0] SEG7_DASH  = 7'h40;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'd0,
        BLINK_HRS  = 2'd1,
        BLINK_MIN  = 2'd2,
        BLINK_SEC  = 2'd3
    } blink_sel_t;

    typedef logic [2:0] digit_idx_t;

    localparam digit_idx_t LAST_DIGIT = 3'd5;

    // Which time field a digit position belongs to; never returns BLINK_NONE.
    function automatic blink_sel_t field_of(input digit_idx_t idx);
        blink_sel_t f;
        case (idx)
            3'd0, 3'd1: f = BLINK_HRS;
            3'd2, 3'd3: f = BLINK_MIN;
            default:    f = BLINK_SEC;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/clock_disp_scan_seg7_decode.sv
// Combinational BCD to seven-segment decoder, active-high g..a.
// Values above 9 decode to a dash.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [7:0] val_i,
    output logic [6:0] code_o
);

    always_comb begin
        case (val_i)
            8'd0:    code_o = SEG7_0;
            8'd1:    code_o = SEG7_1;
            8'd2:    code_o = SEG7_2;
            8'd3:    code_o = SEG7_3;
            8'd4:    code_o = SEG7_4;
            8'd5:    code_o = SEG7_5;
            8'd6:    code_o = SEG7_6;
            8'd7:    code_o = SEG7_7;
            8'd8:    code_o = SEG7_8;
            8'd9:    code_o = SEG7_9;
            default: code_o = SEG7_DASH;
        endcase
    end

endmodule

// File: rtl/clock_disp_scan.sv
// Multiplexed six-digit display scanner with frame-shadowed digits,
// hours-tens zero blanking, field blinking and a blinking colon.
module clock_disp_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] hrs_tens,
    input  logic [7:0] hrs_ones,
    input  logic [7:0] min_tens,
    input  logic [7:0] min_ones,
    input  logic [7:0] sec_tens,
    input  logic [7:0] sec_ones,
    input  logic [1:0] blink_sel,
    output logic [7:0] seg,
    output logic [5:0] an
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_DIV - 1);
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [5:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [PRESC_W-1:0] presc_q, presc_d;
    digit_idx_t         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [7:0]         shadow_q [NUM_DIGITS];
    logic [7:0]         shadow_d [NUM_DIGITS];
    logic [7:0]         in_vals  [NUM_DIGITS];
    logic [6:0]         dec_code [NUM_DIGITS];
    logic [7:0]         seg_q, seg_d;
    logic [5:0]         an_q, an_d;

    logic               tick;
    logic [7:0]         cur_val;
    logic [6:0]         cur_code;
    logic               cur_dp;

    assign in_vals[0] = hrs_tens;
    assign in_vals[1] = hrs_ones;
    assign in_vals[2] = min_tens;
    assign in_vals[3] = min_ones;
    assign in_vals[4] = sec_tens;
    assign in_vals[5] = sec_ones;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            seg7_decode u_dec (
                .val_i  (shadow_q[gi]),
                .code_o (dec_code[gi])
            );
        end
    endgenerate

    always_comb begin
        tick        = en && (presc_q == LAST_PRESC);
        presc_d     = presc_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        shadow_d    = shadow_q;
        cur_val     = '0;
        cur_code    = SEG7_BLANK;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == digit_idx_t'(i)) begin
                cur_val  = shadow_q[i];
                cur_code = dec_code[i];
            end
        end

        if (idx_q == 3'd0 && cur_val == 8'd0) begin
            cur_code = SEG7_BLANK;
        end
        if (!phase_q && field_of(idx_q) == blink_sel_t'(blink_sel)) begin
            cur_code = SEG7_BLANK;
        end
        cur_dp = phase_q && (idx_q == 3'd1 || idx_q == 3'd3);

        if (en) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            // Latch a whole frame at once so a digit never changes mid-scan.
            if (idx_q == 3'd0 && presc_q == '0) begin
                shadow_d = in_vals;
            end
            if (tick) begin
                if (idx_q == LAST_DIGIT) begin
                    idx_d = 3'd0;
                    if (blink_cnt_q == LAST_BLINK) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end

        // XOR with the off pattern applies the board polarity in one place.
        seg_d = en ? ({cur_dp, cur_code} ^ SEG_OFF) : SEG_OFF;
        an_d  = en ? ((6'd1 << idx_q) ^ AN_OFF) : AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
            end
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Directed bench for clock_disp_scan with SCAN_DIV=4, BLINK_DIV=2.
// Edge k counts edges since scanning started; output at edge k shows digit (k/4)%6.
module tb_clock_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] blink_sel;
    logic [7:0] seg;
    logic [5:0] an;

    int total = 0;
    int bad   = 0;
    int ecnt  = -1;

    logic [7:0] exp_f0 [6] = '{8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82};

    always #5 clk = ~clk;

    clock_disp_scan #(
        .SCAN_DIV       (4),
        .BLINK_DIV      (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .hrs_tens  (hrs_tens),
        .hrs_ones  (hrs_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .blink_sel (blink_sel),
        .seg       (seg),
        .an        (an)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s val=%h", tag, got);
        end
    endtask

    // Advance to just after scan edge k (edges with en=0 are not counted).
    task automatic adv(input int k);
        while (ecnt < k) begin
            @(posedge clk);
            #1;
            ecnt++;
        end
    endtask

    task automatic set_digits(input logic [7:0] a, b, c, d, e, f);
        hrs_tens = a; hrs_ones = b; min_tens = c;
        min_ones = d; sec_tens = e; sec_ones = f;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        blink_sel = 2'd0;
        set_digits(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("rst_an%0d", i), {2'b00, an}, 8'h3F);
            check_val($sformatf("rst_seg%0d", i), seg, 8'hFF);
        end
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_an", {2'b00, an}, 8'h3F);
        check_val("post_rst_seg", seg, 8'hFF);

        // Frame 0: plain scan order, colon visible
        en = 1'b1;
        ecnt = -1;
        for (int d = 0; d < 6; d++) begin
            logic [5:0] an_exp;
            an_exp = 6'h3F ^ (6'd1 << d);
            adv(4 * d);
            check_val($sformatf("f0_an_first%0d", d), {2'b00, an}, {2'b00, an_exp});
            adv(4 * d + 2);
            check_val($sformatf("f0_an_mid%0d", d), {2'b00, an}, {2'b00, an_exp});
            check_val($sformatf("f0_seg%0d", d), seg, exp_f0[d]);
            adv(4 * d + 3);
            check_val($sformatf("f0_an_last%0d", d), {2'b00, an}, {2'b00, an_exp});
        end

        // Frame 1: zero blanking, dash, tear-free update of sec_ones
        adv(23);
        set_digits(8'd0, 8'd1, 8'd2, 8'd12, 8'd4, 8'd3);
        adv(26); check_val("f1_zero_blank", seg, 8'hFF);
        adv(30); check_val("f1_d1_colon", seg, 8'h79);
        adv(33); sec_ones = 8'd7;
        adv(38); check_val("f1_dash_dp", seg, 8'h3F);
        adv(46); check_val("f1_d5_old", seg, 8'hB0);

        // Frames 2-3 blink hidden, frame 4 visible again
        adv(47);
        set_digits(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7);
        blink_sel = 2'd2;
        adv(50); check_val("f2_d0", seg, 8'hF9);
        adv(54); check_val("f2_d1_nocolon", seg, 8'hA4);
        adv(58); check_val("f2_d2_blank", seg, 8'hFF);
        adv(62); check_val("f2_d3_blank", seg, 8'hFF);
        adv(66); check_val("f2_d4", seg, 8'h92);
        adv(70); check_val("f2_d5_new", seg, 8'hF8);
        adv(78); check_val("f3_d1_nocolon", seg, 8'hA4);
        adv(82); check_val("f3_d2_blank", seg, 8'hFF);
        adv(98); check_val("f4_d0", seg, 8'hF9);
        adv(102); check_val("f4_d1_colon", seg, 8'h24);
        adv(106); check_val("f4_d2_shown", seg, 8'hB0);
        adv(110); check_val("f4_d3_shown", seg, 8'h19);

        // en gating at digit 4, prescaler 2
        adv(137);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("en0_an%0d", i), {2'b00, an}, 8'h3F);
            check_val($sformatf("en0_seg%0d", i), seg, 8'hFF);
        end
        en = 1'b1;
        adv(138);
        check_val("resume_an_a", {2'b00, an}, 8'h2F);
        check_val("resume_seg", seg, 8'h92);
        adv(139); check_val("resume_an_b", {2'b00, an}, 8'h2F);
        adv(140); check_val("resume_next", {2'b00, an}, 8'h1F);

        // Reset at digit 3, prescaler 2, while blink phase is hidden
        adv(157);
        blink_sel = 2'd0;
        set_digits(8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_an", {2'b00, an}, 8'h3F);
        check_val("mid_rst_seg", seg, 8'hFF);
        rst = 1'b0;
        ecnt = -1;
        adv(0); check_val("restart_an", {2'b00, an}, 8'h3E);
        adv(2); check_val("restart_d0", seg, 8'h90);
        adv(6);
        check_val("restart_d1_an", {2'b00, an}, 8'h3D);
        check_val("restart_d1_colon", seg, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
